// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam logic PC_SRC_INC = 1'b0;
    localparam logic PC_SRC_BR  = 1'b1;

    // Smallest counter width able to hold max_wait (never below one bit).
    function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
        return (max_wait < 32'd2) ? 32'd1 : $clog2(max_wait + 32'd1);
    endfunction

endpackage

// File: rtl/fetch_timeout.sv
// Wait-cycle counter for an outstanding memory request; flags when MAX_WAIT
// ackless cycles have elapsed.
module fetch_timeout
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned CNT_W = wait_cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_r;

    // Counter saturates at the limit so it can never alias back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    assign hit = (cnt_r == LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: req/ack with instruction memory, holds the word for decode,
// and issues the PC write enable / PC source select on each accepted instruction.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [WIDTH-1:0]   pc,
    input  logic               branch_taken,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               pc_we,
    output logic               pc_src,
    output logic               fault,
    output logic [31:0]        fetch_cnt
);

    fetch_state_t       state_r;
    fetch_state_t       next_state_s;
    logic [INSTR_W-1:0] instr_r;
    logic               fault_r;
    logic [31:0]        fetch_cnt_r;
    logic               capture_s;
    logic               handshake_s;
    logic               wait_clr_s;
    logic               wait_en_s;
    logic               wait_hit_s;

    fetch_timeout #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr_s),
        .en  (wait_en_s),
        .hit (wait_hit_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and handshake outputs; an ack on the limit cycle beats the timeout.
    always_comb begin
        next_state_s = state_r;
        imem_req     = 1'b0;
        imem_addr    = {WIDTH{1'b0}};
        instr_valid  = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_INC;
        capture_s    = 1'b0;
        handshake_s  = 1'b0;
        wait_clr_s   = 1'b0;
        wait_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    capture_s    = 1'b1;
                    wait_clr_s   = 1'b1;
                    next_state_s = HOLD;
                end else if (wait_hit_s) begin
                    next_state_s = ERR;
                end else begin
                    wait_en_s    = 1'b1;
                    next_state_s = FETCH;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    handshake_s  = 1'b1;
                    pc_we        = 1'b1;
                    pc_src       = branch_taken ? PC_SRC_BR : PC_SRC_INC;
                    next_state_s = run ? FETCH : IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            ERR: begin
                next_state_s = ERR;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Instruction holding register, sticky fault and retired-fetch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r     <= {INSTR_W{1'b0}};
            fault_r     <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else begin
            if (capture_s) begin
                instr_r <= imem_rdata;
            end
            if (next_state_s == ERR) begin
                fault_r <= 1'b1;
            end
            if (handshake_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
        end
    end

    assign instr     = instr_r;
    assign fault     = fault_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run, branch_taken, imem_ack, instr_ready;
    logic [31:0] pc, imem_rdata;
    logic        imem_req, instr_valid, pc_we, pc_src, fault;
    logic [31:0] imem_addr, instr, fetch_cnt;

    int vectors = 0;
    int miscompares = 0;

    fetch_ctrl #(.WIDTH(32), .INSTR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .pc           (pc),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .fault        (fault),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, ack, ready, br;
        logic [31:0] rdata;
        logic        e_req, e_valid, e_we, e_src;
        logic [31:0] e_instr, e_cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        run = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        pc = 32'h0; imem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state: a pending request, a held word, a fault flag.
    bit          m_req, m_have, m_fault;
    int          m_waits;
    logic [31:0] m_word, m_cnt;

    task automatic model_clear();
        m_req = 1'b0; m_have = 1'b0; m_fault = 1'b0; m_waits = 0;
        m_word = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_step();
        if (m_fault) begin
        end else if (m_req) begin
            if (imem_ack) begin
                m_word = imem_rdata; m_have = 1'b1; m_req = 1'b0; m_waits = 0;
            end else if (m_waits == MAX_WAIT) begin
                m_fault = 1'b1; m_req = 1'b0;
            end else begin
                m_waits++;
            end
        end else if (m_have) begin
            if (instr_ready) begin
                m_have = 1'b0; m_cnt = m_cnt + 32'd1; m_req = run;
            end
        end else begin
            m_req = run;
        end
    endtask

    initial begin
        idle_inputs();
        // rows: run ack ready br rdata | req valid we src instr cnt
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h00500093, 1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,1'b0,32'h00500093, 32'd0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,32'h12345678, 1'b1,1'b0,1'b0,1'b0,32'h00500093, 32'd1};
        for (int i = 6; i < 10; i++)
            tbl[i] = '{1'b1,1'b0,1'b0,1'b1,32'h0,     1'b0,1'b1,1'b0,1'b0,32'h12345678, 32'd1};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b1,32'h0,        1'b0,1'b1,1'b1,1'b1,32'h12345678, 32'd1};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h12345678, 32'd2};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,32'hDEADBEEF, 1'b1,1'b0,1'b0,1'b0,32'h12345678, 32'd2};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,1'b0,32'hDEADBEEF, 32'd2};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'd3};

        do_reset();
        #1;
        chk("reset.req", 32'(imem_req), 32'd0);
        chk("reset.valid", 32'(instr_valid), 32'd0);
        chk("reset.fault", 32'(fault), 32'd0);
        chk("reset.instr", instr, 32'h0);
        chk("reset.cnt", fetch_cnt, 32'd0);
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            run = tbl[i].run; imem_ack = tbl[i].ack; instr_ready = tbl[i].ready;
            branch_taken = tbl[i].br; imem_rdata = tbl[i].rdata; pc = 32'h100 + 32'(i * 4);
            #1;
            chk($sformatf("row%0d.req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d.valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d.pc_we", i), 32'(pc_we), 32'(tbl[i].e_we));
            chk($sformatf("row%0d.pc_src", i), 32'(pc_src), 32'(tbl[i].e_src));
            chk($sformatf("row%0d.instr", i), instr, tbl[i].e_instr);
            chk($sformatf("row%0d.cnt", i), fetch_cnt, tbl[i].e_cnt);
            if (tbl[i].e_req) chk($sformatf("row%0d.addr", i), imem_addr, pc);
            @(negedge clk);
        end

        // Timeout: the limit cycle follows MAX_WAIT ackless cycles; no ack there faults.
        do_reset();
        run = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= MAX_WAIT; k++) begin
            #1;
            chk($sformatf("to.req%0d", k), 32'(imem_req), 32'd1);
            chk($sformatf("to.fault%0d", k), 32'(fault), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("to.fault", 32'(fault), 32'd1);
        chk("to.req_off", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("err.sticky", 32'(fault), 32'd1);
        chk("err.valid", 32'(instr_valid), 32'd0);
        chk("err.req", 32'(imem_req), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("err.rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0; idle_inputs();

        // Ack on the limit cycle wins.
        do_reset();
        run = 1'b1;
        @(negedge clk);
        repeat (MAX_WAIT) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hA5A50001;
        #1;
        chk("lim.req", 32'(imem_req), 32'd1);
        @(negedge clk);
        imem_ack = 1'b0; run = 1'b0;
        #1;
        chk("lim.fault", 32'(fault), 32'd0);
        chk("lim.valid", 32'(instr_valid), 32'd1);
        chk("lim.instr", instr, 32'hA5A50001);

        // Asynchronous reset mid-FETCH, then a late ack.
        do_reset();
        run = 1'b1; pc = 32'h40;
        @(negedge clk);
        #1;
        chk("ar.req_before", 32'(imem_req), 32'd1);
        chk("ar.addr", imem_addr, 32'h40);
        #2 rst = 1'b1;
        #1;
        chk("ar.req", 32'(imem_req), 32'd0);
        chk("ar.valid", 32'(instr_valid), 32'd0);
        chk("ar.fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        #1;
        chk("late.valid", 32'(instr_valid), 32'd0);
        chk("late.instr", instr, 32'h0);
        imem_ack = 1'b0;

        // Counter wrap.
        do_reset();
        force dut.fetch_cnt_r = 32'hFFFFFFFF;
        #1 release dut.fetch_cnt_r;
        #1;
        chk("wrap.pre", fetch_cnt, 32'hFFFFFFFF);
        run = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h1;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; run = 1'b0;
        @(negedge clk);
        #1;
        chk("wrap.post", fetch_cnt, 32'h0);

        // Randomized run against the reference model.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            model_clear();
            for (int cyc = 0; cyc < 500; cyc++) begin
                run = ($urandom_range(0, 9) != 0);
                imem_ack = (blk % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
                instr_ready = $urandom_range(0, 1) == 1;
                branch_taken = $urandom_range(0, 1) == 1;
                pc = $urandom; imem_rdata = $urandom;
                #1;
                chk("rnd.req", 32'(imem_req), 32'(m_req && !m_fault));
                chk("rnd.valid", 32'(instr_valid), 32'(m_have));
                chk("rnd.pc_we", 32'(pc_we), 32'(m_have && instr_ready));
                chk("rnd.pc_src", 32'(pc_src), 32'(m_have && instr_ready && branch_taken));
                chk("rnd.fault", 32'(fault), 32'(m_fault));
                chk("rnd.instr", instr, m_word);
                chk("rnd.cnt", fetch_cnt, m_cnt);
                if (m_req && !m_fault) chk("rnd.addr", imem_addr, pc);
                @(posedge clk);
                model_step();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the PC datapath (PC register, +4 / +ImmOp adders, PCsrc mux).
- Runs a req/ack handshake with instruction memory at the current PC and holds the fetched word until decode accepts it.
- On each accepted instruction it issues a one-cycle PC write enable and the PCsrc select.
- Detects memory timeouts and counts retired fetches.

Parameters:
- WIDTH, 32, PC/address width.
- INSTR_W, 32, instruction width.
- MAX_WAIT, 15, cycles without ack before fault; legal range 1..255.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable fetching.
- pc  in  WIDTH  current PC from PC register.
- branch_taken  in  1  branch decision for the instruction being accepted.
- imem_req  out  1  memory request.
- imem_addr  out  WIDTH  request address.
- imem_ack  in  1  memory data valid.
- imem_rdata  in  INSTR_W  memory data.
- instr  out  INSTR_W  held instruction.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode accepts.
- pc_we  out  1  PC register write enable.
- pc_src  out  1  0 = PC+4, 1 = PC+ImmOp.
- fault  out  1  sticky timeout flag.
- fetch_cnt  out  32  accepted-instruction count.

Behaviour:
- Reset is asynchronous and takes effect immediately:
  - state=IDLE.
  - imem_req, instr_valid, pc_we, pc_src, fault = 0.
  - instr = 0, fetch_cnt = 0, wait counter = 0.
- Reset mid-request drops imem_req in the same cycle. Any later ack is ignored.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE:
  - All handshake outputs 0.
  - run=1 moves to FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, both driven combinationally from state.
  - imem_addr is stable while in FETCH because pc_we=0 there.
  - imem_ack=1: register instr<=imem_rdata, clear wait counter, go to HOLD. instr_valid rises the cycle after ack, so ack-to-valid latency is 1.
  - No ack: wait counter increments each cycle.
  - If the counter equals MAX_WAIT and no ack arrives: go to ERR and set fault.
  - An ack in the same cycle as the limit wins, so there is no fault.
- HOLD:
  - instr_valid=1 and instr is stable.
  - Handshake occurs when instr_valid and instr_ready are both 1. In that cycle (combinational outputs):
    - pc_we=1.
    - pc_src=branch_taken.
    - fetch_cnt increments on the edge and wraps 0xFFFFFFFF -> 0.
  - After the handshake: go to FETCH if run=1, else IDLE.
  - No handshake: stay in HOLD. pc_we=0, pc_src=0.
- pc_we is never asserted outside a HOLD handshake cycle, so at most one PC update per fetched instruction.
- branch_taken is sampled only during the handshake cycle and is don't-care otherwise.
- run deasserted in FETCH or HOLD: the outstanding transaction completes normally (ack, then handshake), then the block goes to IDLE. No request is ever abandoned.
- imem_ack outside FETCH is ignored.
- ERR:
  - imem_req=0, instr_valid=0, fault=1.
  - Exit only via rst.
- Wait counter width is the minimum needed to hold MAX_WAIT.

Decomposition:
- Shared package fetch_pkg:
  - State enum fetch_state_t (IDLE, FETCH, HOLD, ERR).
  - Constants PC_SRC_INC=0 and PC_SRC_BR=1.
- One natural sub-module: fetch_timeout, the wait counter with clear, enable and limit-hit output, parameterized by MAX_WAIT.
- The FSM and handshake logic stay in fetch_ctrl.

Test Plan:
- Reset then run=1, pc=0x0, ack after 2 wait cycles with rdata=0x00500093, ready=1:
  - imem_req high for 3 cycles.
  - instr=0x00500093 with instr_valid=1 the next cycle.
  - pc_we pulses once with pc_src=0, and fetch_cnt=1.
- Handshake with branch_taken=1 -> pc_src=1 in exactly that cycle with pc_we=1. With ready held low for 4 cycles, pc_we stays 0 and instr remains stable.
- MAX_WAIT=15, no ack -> fault=1 and ERR after 15 wait cycles, imem_req=0. An ack exactly at cycle 15 produces no fault.
- run dropped in the cycle after imem_req rises -> ack still captured, handshake completes, then IDLE with imem_req=0.
- rst asserted mid-FETCH, not on a clock edge -> imem_req, instr_valid and fault go to 0 immediately. A late ack after reset is ignored.
- Preload fetch_cnt near wrap via 0xFFFFFFFF handshakes, or force in sim -> the next handshake gives 0x00000000.
